// File: rtl/traffic_pkg.sv
// Shared encodings for the highway/farm-road light controller and its detector front-end.
package traffic_pkg;

  localparam logic [2:0] LIGHT_GREEN  = 3'b001;
  localparam logic [2:0] LIGHT_YELLOW = 3'b010;
  localparam logic [2:0] LIGHT_RED    = 3'b100;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQUEST = 2'd1,
    SERVE   = 2'd2
  } det_state_t;

  typedef enum logic [1:0] {
    LF_GREEN  = 2'd0,
    LF_YELLOW = 2'd1,
    LF_RED    = 2'd2
  } light_t;

  // Anything that is not a clean one-hot green/yellow is treated as red (fail safe).
  function automatic light_t decode_light(input logic [2:0] l_f);
    light_t w_light;
    case (l_f)
      LIGHT_GREEN:  w_light = LF_GREEN;
      LIGHT_YELLOW: w_light = LF_YELLOW;
      default:      w_light = LF_RED;
    endcase
    return w_light;
  endfunction

endpackage

// File: rtl/det_debounce.sv
// Loop-detector conditioner: 2-flop synchroniser, stability-count debouncer and
// a one-cycle pulse on each accepted rising edge.
module det_debounce #(
  parameter int DEB_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout,
  output logic rise
);

  localparam int CW = $clog2(DEB_CYCLES + 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_level;
  logic          r_level_q;
  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= din;
      r_sync2 <= r_sync1;
    end
  end

  // The level only flips once the disagreement has lasted DEB_CYCLES cycles in a row.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_level   <= 1'b0;
      r_level_q <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_level_q <= r_level;
      if (r_sync2 != r_level) begin
        if (r_cnt == CW'(DEB_CYCLES - 1)) begin
          r_level <= r_sync2;
          r_cnt   <= '0;
        end else begin
          r_cnt <= r_cnt + CW'(1);
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign dout = r_level;
  assign rise = r_level & ~r_level_q;

endmodule

// File: rtl/farm_road_detector.sv
// Farm-road vehicle detector: counts debounced arrivals/departures into a
// saturating queue and raises sensor to the light controller while it is non-empty.
module farm_road_detector
  import traffic_pkg::*;
#(
  parameter int DEB_CYCLES = 4,
  parameter int CNT_W      = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             loop_in,
  input  logic             exit_in,
  input  logic [2:0]       l_f,
  output logic             sensor,
  output logic [CNT_W-1:0] queue_cnt,
  output logic             overflow
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic             w_arrive;
  logic             w_depart;
  logic             w_loop_lvl_unused;
  logic             w_exit_lvl_unused;
  light_t           w_light;
  det_state_t       r_state;
  det_state_t       w_next;
  logic [CNT_W-1:0] r_queue_cnt;
  logic             r_overflow;
  logic             r_sensor;

  // Only the edge pulses feed the queue; the debounced levels are left for probing.
  det_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_loop_deb (
    .clk  (clk),
    .rst  (rst),
    .din  (loop_in),
    .dout (w_loop_lvl_unused),
    .rise (w_arrive)
  );

  det_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_exit_deb (
    .clk  (clk),
    .rst  (rst),
    .din  (exit_in),
    .dout (w_exit_lvl_unused),
    .rise (w_depart)
  );

  // A lost arrival at full scale is latched; a departure from empty is simply ignored.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_queue_cnt <= '0;
      r_overflow  <= 1'b0;
    end else begin
      case ({w_arrive, w_depart})
        2'b10: begin
          if (r_queue_cnt == CNT_MAX) begin
            r_overflow <= 1'b1;
          end else begin
            r_queue_cnt <= r_queue_cnt + CNT_W'(1);
          end
        end
        2'b01: begin
          if (r_queue_cnt != '0) begin
            r_queue_cnt <= r_queue_cnt - CNT_W'(1);
          end
        end
        default: r_queue_cnt <= r_queue_cnt;
      endcase
    end
  end

  assign w_light = decode_light(l_f);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= IDLE;
      r_sensor <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_sensor <= (w_next != IDLE);
    end
  end

  // An empty queue always wins: there is nothing to serve, so drop the request.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (r_queue_cnt != '0) w_next = REQUEST;
      end
      REQUEST: begin
        if (r_queue_cnt == '0)         w_next = IDLE;
        else if (w_light == LF_GREEN)  w_next = SERVE;
      end
      SERVE: begin
        if (r_queue_cnt == '0)         w_next = IDLE;
        else if (w_light == LF_RED)    w_next = REQUEST;
      end
      default: w_next = IDLE;
    endcase
  end

  assign sensor    = r_sensor;
  assign queue_cnt = r_queue_cnt;
  assign overflow  = r_overflow;

endmodule

// File: tb/tb_farm_road_detector.sv
// Scoreboard bench for farm_road_detector: stimulus queues expected outputs per clock
// edge, an independent monitor compares them on the falling edge.
module tb_farm_road_detector;
   import traffic_pkg::*;

   logic       clk = 1'b0;
   logic       rst;
   logic       loopIn;
   logic       exitIn;
   logic [2:0] lF;
   logic       sensor;
   logic [3:0] queueCnt;
   logic       overflow;

   int edgeCnt = 0;
   int checks  = 0;
   int errors  = 0;

   typedef struct {
      int         cyc;
      string      name;
      logic       s;
      logic [3:0] c;
      logic       o;
      det_state_t st;
   } exp_t;

   exp_t sb[$];

   farm_road_detector #(.DEB_CYCLES(4), .CNT_W(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .loop_in   (loopIn),
      .exit_in   (exitIn),
      .l_f       (lF),
      .sensor    (sensor),
      .queue_cnt (queueCnt),
      .overflow  (overflow)
   );

   // Free-running clock, 10 time units per period.
   always #5 clk = ~clk;

   // Count rising edges so expectations can be tied to an absolute edge number.
   always @(posedge clk) edgeCnt <= edgeCnt + 1;

   // Monitor: retire every expectation due at (or overdue by) the current edge count.
   always @(negedge clk) begin
      exp_t e;
      while (sb.size() > 0 && sb[0].cyc <= edgeCnt) begin
         e = sb.pop_front();
         checks++;
         if (e.cyc != edgeCnt || sensor !== e.s || queueCnt !== e.c ||
             overflow !== e.o || dut.r_state !== e.st) begin
            errors++;
            $display("[TB] FAIL %s at edge %0d (due %0d): got sensor=%b cnt=%0d ovf=%b state=%0d, want sensor=%b cnt=%0d ovf=%b state=%0d",
                     e.name, edgeCnt, e.cyc, sensor, queueCnt, overflow, int'(dut.r_state),
                     e.s, e.c, e.o, int'(e.st));
         end
      end
   end

   task automatic checkOutput(input string name, input int offset, input logic s,
                              input logic [3:0] c, input logic o, input det_state_t st);
      exp_t e;
      e.cyc  = edgeCnt + offset;
      e.name = name;
      e.s    = s;
      e.c    = c;
      e.o    = o;
      e.st   = st;
      sb.push_back(e);
   endtask

   task automatic applyStimulus(input logic lp, input logic ex, input logic [2:0] lf);
      @(negedge clk);
      loopIn = lp;
      exitIn = ex;
      lF     = lf;
   endtask

   // One clean detector event: held 6 cycles, then released 6 cycles so it debounces back low.
   task automatic vehicle(input logic lp, input logic ex);
      applyStimulus(lp, ex, lF);
      repeat (5) @(negedge clk);
      applyStimulus(1'b0, 1'b0, lF);
      repeat (5) @(negedge clk);
   endtask

   // Main sequence: walks through every test-plan item in order.
   initial begin
      int guard;
      rst    = 1'b1;
      loopIn = 1'b0;
      exitIn = 1'b0;
      lF     = LIGHT_RED;
      #2 rst = 1'b0;

      // Reset held with a toggling loop input.
      for (int i = 0; i < 20; i++) begin
         applyStimulus(~loopIn, 1'b0, LIGHT_RED);
         if (i % 5 == 4) checkOutput("reset_hold", 1, 1'b0, 4'd0, 1'b0, IDLE);
      end
      checks++;
      if (sensor !== 1'b0 || queueCnt !== 4'd0 || overflow !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_hold_direct: sensor=%b cnt=%0d ovf=%b", sensor, queueCnt, overflow);
      end
      applyStimulus(1'b0, 1'b0, LIGHT_RED);
      rst = 1'b1;
      checkOutput("post_reset_a", 4, 1'b0, 4'd0, 1'b0, IDLE);
      checkOutput("post_reset_b", 12, 1'b0, 4'd0, 1'b0, IDLE);
      repeat (12) @(negedge clk);

      // Single arrival with exact edge timing.
      applyStimulus(1'b1, 1'b0, LIGHT_RED);
      checkOutput("arr_edge6", 6, 1'b0, 4'd0, 1'b0, IDLE);
      checkOutput("arr_edge7", 7, 1'b0, 4'd1, 1'b0, IDLE);
      checkOutput("arr_edge8", 8, 1'b1, 4'd1, 1'b0, REQUEST);
      repeat (9) @(negedge clk);
      applyStimulus(1'b0, 1'b0, LIGHT_RED);
      repeat (10) @(negedge clk);
      checkOutput("arr_hold", 1, 1'b1, 4'd1, 1'b0, REQUEST);
      vehicle(1'b0, 1'b1);
      checkOutput("arr_drain", 1, 1'b0, 4'd0, 1'b0, IDLE);

      // Glitches of 1, 2 and 3 cycles must be rejected.
      for (int len = 1; len <= 3; len++) begin
         applyStimulus(1'b1, 1'b0, LIGHT_RED);
         repeat (len - 1) @(negedge clk);
         applyStimulus(1'b0, 1'b0, LIGHT_RED);
         repeat (4) @(negedge clk);
         checkOutput("glitch", 1, 1'b0, 4'd0, 1'b0, IDLE);
      end
      repeat (8) @(negedge clk);
      checkOutput("glitch_settle", 1, 1'b0, 4'd0, 1'b0, IDLE);

      // Service cycle.
      vehicle(1'b1, 1'b0);
      vehicle(1'b1, 1'b0);
      vehicle(1'b1, 1'b0);
      checkOutput("svc_three", 1, 1'b1, 4'd3, 1'b0, REQUEST);
      applyStimulus(1'b0, 1'b0, LIGHT_GREEN);
      checkOutput("svc_serve", 1, 1'b1, 4'd3, 1'b0, SERVE);
      applyStimulus(1'b0, 1'b0, LIGHT_YELLOW);
      vehicle(1'b0, 1'b1);
      checkOutput("svc_dep_yellow", 1, 1'b1, 4'd2, 1'b0, SERVE);
      applyStimulus(1'b0, 1'b0, LIGHT_RED);
      checkOutput("svc_red_req", 1, 1'b1, 4'd2, 1'b0, REQUEST);
      vehicle(1'b0, 1'b1);
      checkOutput("svc_dep_red", 1, 1'b1, 4'd1, 1'b0, REQUEST);
      applyStimulus(1'b0, 1'b0, LIGHT_GREEN);
      checkOutput("svc_green2", 1, 1'b1, 4'd1, 1'b0, SERVE);
      applyStimulus(1'b0, 1'b1, LIGHT_GREEN);
      checkOutput("svc_dep3_e6", 6, 1'b1, 4'd1, 1'b0, SERVE);
      checkOutput("svc_dep3_e7", 7, 1'b1, 4'd0, 1'b0, SERVE);
      checkOutput("svc_dep3_e8", 8, 1'b0, 4'd0, 1'b0, IDLE);
      repeat (5) @(negedge clk);
      applyStimulus(1'b0, 1'b0, LIGHT_GREEN);
      repeat (5) @(negedge clk);

      // Saturation.
      applyStimulus(1'b0, 1'b0, LIGHT_RED);
      for (int i = 1; i <= 16; i++) begin
         vehicle(1'b1, 1'b0);
         if (i == 1)  checkOutput("sat_first", 1, 1'b1, 4'd1, 1'b0, REQUEST);
         if (i == 15) checkOutput("sat_full", 1, 1'b1, 4'd15, 1'b0, REQUEST);
         if (i == 16) checkOutput("sat_overflow", 1, 1'b1, 4'd15, 1'b1, REQUEST);
      end
      vehicle(1'b0, 1'b1);
      checkOutput("sat_dep", 1, 1'b1, 4'd14, 1'b1, REQUEST);

      // Asynchronous reset mid-SERVE.
      applyStimulus(1'b0, 1'b0, LIGHT_GREEN);
      checkOutput("sat_serve", 1, 1'b1, 4'd14, 1'b1, SERVE);
      repeat (2) @(negedge clk);
      @(posedge clk);
      #1 rst = 1'b0;
      checkOutput("rst_async", 0, 1'b0, 4'd0, 1'b0, IDLE);
      #1;
      checks++;
      if (sensor !== 1'b0 || queueCnt !== 4'd0 || overflow !== 1'b0) begin
         errors++;
         $display("[TB] FAIL rst_async_direct: sensor=%b cnt=%0d ovf=%b", sensor, queueCnt, overflow);
      end
      @(posedge clk);
      #1 rst = 1'b1;
      checkOutput("rst_after", 1, 1'b0, 4'd0, 1'b0, IDLE);
      @(negedge clk);

      // Departure from an empty queue.
      vehicle(1'b0, 1'b1);
      checkOutput("dep_at_zero", 1, 1'b0, 4'd0, 1'b0, IDLE);

      // Illegal light code in SERVE decodes as red.
      vehicle(1'b1, 1'b0);
      checkOutput("bad_lf_first", 1, 1'b1, 4'd1, 1'b0, SERVE);
      vehicle(1'b1, 1'b0);
      checkOutput("bad_lf_serve", 1, 1'b1, 4'd2, 1'b0, SERVE);
      applyStimulus(1'b0, 1'b0, 3'b110);
      checkOutput("bad_lf_req", 1, 1'b1, 4'd2, 1'b0, REQUEST);

      // Coincident arrival and departure at five.
      vehicle(1'b1, 1'b0);
      vehicle(1'b1, 1'b0);
      vehicle(1'b1, 1'b0);
      checkOutput("coinc_pre", 1, 1'b1, 4'd5, 1'b0, REQUEST);
      vehicle(1'b1, 1'b1);
      checkOutput("coinc_hold", 1, 1'b1, 4'd5, 1'b0, REQUEST);

      guard = 0;
      while (sb.size() > 0 && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      while (sb.size() > 0) begin
         checks++;
         errors++;
         $display("[TB] FAIL %s never checked: due edge %0d, now %0d", sb[0].name, sb[0].cyc, edgeCnt);
         void'(sb.pop_front());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/farm_road_detector.md
# farm_road_detector

Front-end for the highway/farm-road traffic light controller: it drives the controller's `sensor` input and watches the farm-road light `l_f` coming back out. Raw farm-road arrival and departure loop detectors are synchronised, debounced and counted into a vehicle queue. `sensor` is asserted while vehicles wait or are being served, and drops once the queue drains. It sits between the road-side detectors and the light FSM, on the same clock.

## Interface
Parameters:
- `DEB_CYCLES`, default 4: consecutive stable cycles (≥2) a synchronised detector level needs before it is accepted.
- `CNT_W`, default 4: queue counter width; maximum count is 2^CNT_W−1.

Ports:
- `clk`  in  1  system clock; all state on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `loop_in`  in  1  raw arrival loop detector; asynchronous and bouncy.
- `exit_in`  in  1  raw departure loop detector; asynchronous and bouncy.
- `l_f`  in  3  farm-road light from the controller.
- `sensor`  out  1  vehicle-waiting request to the controller.
- `queue_cnt`  out  CNT_W  vehicles currently queued or in service.
- `overflow`  out  1  sticky; set when an arrival is lost at saturation.

## Operation
- Reset (rst=0, asynchronous) clears everything, including mid-operation: sync flops 0, debounced levels 0, debounce counters 0, `queue_cnt`=0, `overflow`=0, state IDLE, `sensor`=0.
- Each of `loop_in` and `exit_in` passes through a 2-flop synchroniser, then its own debouncer:
  - While the synchronised bit differs from the debounced level, the counter increments.
  - When the bit has differed on DEB_CYCLES consecutive cycles, the debounced level flips and the counter clears.
  - Any cycle with agreement clears the counter. Glitches shorter than DEB_CYCLES cycles are rejected.
- A rising edge of debounced loop produces a one-cycle arrival. A rising edge of debounced exit produces a one-cycle departure. Falling edges are ignored.
- Queue update, per cycle:
  - Arrival only: +1. At max, hold and set `overflow`.
  - Departure only: −1. At 0, hold; this is not an error.
  - Both in the same cycle: hold.
- `l_f` decode: 3'b001 GREEN, 3'b010 YELLOW, 3'b100 RED. Any other value is treated as RED.
- FSM, state registered, `sensor` = (state != IDLE):
  - IDLE → REQUEST when `queue_cnt` != 0.
  - REQUEST → SERVE when `l_f`==GREEN. REQUEST → IDLE when `queue_cnt`==0.
  - SERVE → IDLE when `queue_cnt`==0; this takes priority. SERVE → REQUEST when `l_f` decodes RED and `queue_cnt` != 0. SERVE stays through YELLOW.
- `overflow` clears only on reset.

## Timing
- Edge 1 is the first clock edge that samples `loop_in` high, with the input held high throughout:
  - Debounced level rises at edge DEB_CYCLES+2.
  - `queue_cnt` increments at edge DEB_CYCLES+3.
  - `sensor` rises at edge DEB_CYCLES+4.
- Departure path has identical latency. With the FSM in SERVE, the decrement to 0 lands at edge DEB_CYCLES+3 after `exit_in` is first sampled high, and `sensor` falls one edge later.
- `l_f` is synchronous to `clk` and used directly. An `l_f` change is reflected in state at the next edge.
- All outputs are registered. There is no combinational path from input to output.

## Structure
- Shared package `traffic_pkg`: light encodings LIGHT_GREEN, LIGHT_YELLOW, LIGHT_RED (3 bits), and the detector state encoding IDLE/REQUEST/SERVE. The light controller uses the same light constants.
- One sub-module, `det_debounce` (parameter DEB_CYCLES; ports `clk`, `rst`, `din`, `dout`, `rise`), contains the synchroniser, debounce counter and rising-edge pulse. It is instantiated twice.
- Top level holds the saturating queue counter, the `overflow` flag and the FSM.

## Test plan
Run with DEB_CYCLES=4 and CNT_W=4.
1. **Reset.** Hold rst=0 for 20 cycles with `loop_in` toggling → `sensor`=0, `queue_cnt`=0, `overflow`=0. After release, nothing changes until a valid pulse arrives.
2. **Single arrival.** `loop_in` high for 10 cycles, `l_f`=RED → `queue_cnt`=1 at edge 7, `sensor`=1 at edge 8, state REQUEST.
3. **Glitch rejection.** `loop_in` pulses of 1, 2 and 3 cycles separated by 5 low cycles → `queue_cnt` stays 0 and `sensor` stays 0.
4. **Service cycle.** Three arrivals, then `l_f`=GREEN → SERVE. Two departures with `l_f`=YELLOW then RED → REQUEST with `queue_cnt`=1. `l_f`=GREEN, then a third departure → `queue_cnt`=0, `sensor` falls one cycle later, state IDLE.
5. **Saturation.** 16 arrivals with no departures → `queue_cnt`=15 and `overflow`=1 after the 16th. A departure then gives `queue_cnt`=14 with `overflow` still 1.
6. **Edge cases.**
   - Coincident debounced arrival and departure edges at `queue_cnt`=5 → stays 5.
   - Departure at `queue_cnt`=0 → stays 0.
   - `l_f`=3'b110 in SERVE with `queue_cnt`=2 → REQUEST.
   - rst pulled low for 1 cycle mid-SERVE → all outputs return to reset values immediately.
